bp_be_fma_issue_ctl: RTL and testbench



---
 rtl/bp_be_fma_issue_ctl_pkg.sv | 26 ++
 rtl/bp_be_fma_sb_shift.sv | 58 +++++
 rtl/bp_be_fma_issue_ctl.sv | 107 ++++++++++
 tb/tb_bp_be_fma_issue_ctl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_fma_issue_ctl_pkg.sv
// Shared BE definitions for the FMA/IMUL issue controller:
// configuration enum, scoreboard entry layout and per-pipe scoreboard depths.
package bp_be_fma_issue_ctl_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef struct packed {
    logic       v;
    logic       poison;
    logic [4:0] rd;
  } bp_be_fma_sb_entry_s;

  localparam int imul_pipe_latency_gp = 4;
  localparam int fma_pipe_latency_gp  = 5;
  localparam int imul_sb_depth_gp     = imul_pipe_latency_gp - 1;
  localparam int fma_sb_depth_gp      = fma_pipe_latency_gp - 1;

  // Every configuration currently shares the same pipe depths.
  function automatic int sb_depth(bp_params_e cfg, logic imul);
    if (cfg == e_bp_default_cfg) return imul ? imul_sb_depth_gp : fma_sb_depth_gp;
    return imul ? imul_sb_depth_gp : fma_sb_depth_gp;
  endfunction

endpackage

// File: rtl/bp_be_fma_sb_shift.sv
// Scoreboard shift register for one fixed-latency pipe: entries age one slot per cycle,
// young entries are poisoned on flush, and valid source tags are matched against every rd.
module bp_be_fma_sb_shift
  import bp_be_fma_issue_ctl_pkg::*;
#(
  parameter int depth_p      = 3,
  parameter int commit_age_p = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [4:0]         push_rd,
  input  logic               flush,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [4:0]         rs3,
  input  logic [2:0]         rs_v,
  output logic               match,
  output logic [depth_p-1:0] valid,
  output logic               last_poison,
  output logic [4:0]         last_rd
);

  bp_be_fma_sb_entry_s [depth_p-1:0] sb_q;
  bp_be_fma_sb_entry_s [depth_p-1:0] sb_n;

  // Poison is applied as an entry leaves a young slot, so it is seen one slot later.
  always_comb begin
    sb_n       = '0;
    sb_n[0].v  = push;
    sb_n[0].rd = push ? push_rd : 5'd0;
    for (int k = 1; k < depth_p; k++) begin
      sb_n[k] = sb_q[k-1];
      if (flush && sb_q[k-1].v && ((k - 1) < commit_age_p)) sb_n[k].poison = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_n;
  end

  always_comb begin
    match = 1'b0;
    valid = '0;
    for (int k = 0; k < depth_p; k++) begin
      valid[k] = sb_q[k].v;
      if (sb_q[k].v && ((rs_v[0] && (rs1 == sb_q[k].rd)) ||
                        (rs_v[1] && (rs2 == sb_q[k].rd)) ||
                        (rs_v[2] && (rs3 == sb_q[k].rd))))
        match = 1'b1;
    end
  end

  assign last_poison = sb_q[depth_p-1].poison;
  assign last_rd     = sb_q[depth_p-1].rd;

endmodule

// File: rtl/bp_be_fma_issue_ctl.sv
// Issue controller for the fixed-latency FMA/IMUL pipe: RAW/flush stalls, flush-kill and
// writeback tagging. Define BP_BE_FMA_SHARED_WB_EN when imul and fma share one writeback port.
module bp_be_fma_issue_ctl
  import bp_be_fma_issue_ctl_pkg::*;
#(
  parameter bp_params_e bp_params_p  = e_bp_default_cfg,
  parameter int         commit_age_p = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       issue_v_i,
  input  logic       issue_imul_i,
  input  logic [4:0] issue_rd_i,
  input  logic [4:0] issue_rs1_i,
  input  logic [4:0] issue_rs2_i,
  input  logic [4:0] issue_rs3_i,
  input  logic [2:0] issue_rs_v_i,
  input  logic       flush_i,
  input  logic       imul_v_i,
  input  logic       fma_v_i,
  output logic       issue_ready_o,
  output logic       dispatch_v_o,
  output logic       imul_wb_v_o,
  output logic [4:0] imul_wb_rd_o,
  output logic       fma_wb_v_o,
  output logic [4:0] fma_wb_rd_o,
  output logic       idle_o,
  output logic       mismatch_o
);

  localparam int imul_depth_lp = sb_depth(bp_params_p, 1'b1);
  localparam int fma_depth_lp  = sb_depth(bp_params_p, 1'b0);

  logic [imul_depth_lp-1:0] imul_valid;
  logic [fma_depth_lp-1:0]  fma_valid;
  logic                     imul_match, fma_match;
  logic                     imul_last_poison, fma_last_poison;
  logic [2:0]               imul_rs_v, fma_rs_v;
  logic                     wb_collision;
  logic                     mismatch_q;

  // Sources are only compared against the pipe that writes the same register file.
  assign imul_rs_v = issue_imul_i ? issue_rs_v_i : 3'b000;
  assign fma_rs_v  = issue_imul_i ? 3'b000 : issue_rs_v_i;

`ifdef BP_BE_FMA_SHARED_WB_EN
  assign wb_collision = issue_imul_i & fma_valid[0];
`else
  assign wb_collision = 1'b0;
`endif

  assign issue_ready_o = ~flush_i & ~imul_match & ~fma_match & ~wb_collision;
  assign dispatch_v_o  = issue_v_i & issue_ready_o;

  bp_be_fma_sb_shift #(
    .depth_p      (imul_depth_lp),
    .commit_age_p (commit_age_p)
  ) imul_sb (
    .clk         (clk_i),
    .rst         (reset_i),
    .push        (dispatch_v_o & issue_imul_i),
    .push_rd     (issue_rd_i),
    .flush       (flush_i),
    .rs1         (issue_rs1_i),
    .rs2         (issue_rs2_i),
    .rs3         (issue_rs3_i),
    .rs_v        (imul_rs_v),
    .match       (imul_match),
    .valid       (imul_valid),
    .last_poison (imul_last_poison),
    .last_rd     (imul_wb_rd_o)
  );

  bp_be_fma_sb_shift #(
    .depth_p      (fma_depth_lp),
    .commit_age_p (commit_age_p)
  ) fma_sb (
    .clk         (clk_i),
    .rst         (reset_i),
    .push        (dispatch_v_o & ~issue_imul_i),
    .push_rd     (issue_rd_i),
    .flush       (flush_i),
    .rs1         (issue_rs1_i),
    .rs2         (issue_rs2_i),
    .rs3         (issue_rs3_i),
    .rs_v        (fma_rs_v),
    .match       (fma_match),
    .valid       (fma_valid),
    .last_poison (fma_last_poison),
    .last_rd     (fma_wb_rd_o)
  );

  assign imul_wb_v_o = imul_valid[imul_depth_lp-1] & ~imul_last_poison & imul_v_i;
  assign fma_wb_v_o  = fma_valid[fma_depth_lp-1] & ~fma_last_poison & fma_v_i;
  assign idle_o      = ~(|imul_valid) & ~(|fma_valid);

  // A strobe disagreeing with the scoreboard means the pipe and controller lost sync.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) mismatch_q <= 1'b0;
    else if ((imul_valid[imul_depth_lp-1] != imul_v_i) ||
             (fma_valid[fma_depth_lp-1] != fma_v_i))
      mismatch_q <= 1'b1;
  end

  assign mismatch_o = mismatch_q;

endmodule

// File: tb/tb_bp_be_fma_issue_ctl.sv
// Randomized self-checking bench for bp_be_fma_issue_ctl against an in-flight-op list model.
`timescale 1ns/1ps
module tb_bp_be_fma_issue_ctl;

  localparam int COMMIT_AGE = 2;
  localparam int IMUL_DEPTH = 3;
  localparam int FMA_DEPTH  = 4;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       issue_v_i, issue_imul_i;
  logic [4:0] issue_rd_i, issue_rs1_i, issue_rs2_i, issue_rs3_i;
  logic [2:0] issue_rs_v_i;
  logic       flush_i, imul_v_i, fma_v_i;
  logic       issue_ready_o, dispatch_v_o;
  logic       imul_wb_v_o, fma_wb_v_o;
  logic [4:0] imul_wb_rd_o, fma_wb_rd_o;
  logic       idle_o, mismatch_o;

  always #5 clk_i = ~clk_i;

  bp_be_fma_issue_ctl #(.commit_age_p(COMMIT_AGE)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .issue_v_i     (issue_v_i),
    .issue_imul_i  (issue_imul_i),
    .issue_rd_i    (issue_rd_i),
    .issue_rs1_i   (issue_rs1_i),
    .issue_rs2_i   (issue_rs2_i),
    .issue_rs3_i   (issue_rs3_i),
    .issue_rs_v_i  (issue_rs_v_i),
    .flush_i       (flush_i),
    .imul_v_i      (imul_v_i),
    .fma_v_i       (fma_v_i),
    .issue_ready_o (issue_ready_o),
    .dispatch_v_o  (dispatch_v_o),
    .imul_wb_v_o   (imul_wb_v_o),
    .imul_wb_rd_o  (imul_wb_rd_o),
    .fma_wb_v_o    (fma_wb_v_o),
    .fma_wb_rd_o   (fma_wb_rd_o),
    .idle_o        (idle_o),
    .mismatch_o    (mismatch_o)
  );

  // Reference model: list of in-flight ops, each aged in cycles since dispatch.
  typedef struct {
    int       age;
    bit       imul;
    bit [4:0] rd;
    bit       poison;
  } op_t;

  op_t inflight[$];
  bit  model_mismatch;
  int  checks;
  int  failures;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelLast(input bit imul, output bit poison, output bit [4:0] rd);
    poison = 1'b0;
    rd     = 5'd0;
    foreach (inflight[i])
      if (inflight[i].imul == imul && inflight[i].age == (imul ? IMUL_DEPTH : FMA_DEPTH)) begin
        poison = inflight[i].poison;
        rd     = inflight[i].rd;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit modelReady();
    logic [4:0] src [3];
    src[0] = issue_rs1_i;
    src[1] = issue_rs2_i;
    src[2] = issue_rs3_i;
    if (flush_i) return 1'b0;
    foreach (inflight[i])
      if (inflight[i].imul == issue_imul_i)
        for (int s = 0; s < 3; s++)
          if (issue_rs_v_i[s] && src[s] == inflight[i].rd) return 1'b0;
`ifdef BP_BE_FMA_SHARED_WB_EN
    if (issue_imul_i)
      foreach (inflight[i])
        if (!inflight[i].imul && inflight[i].age == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic modelStep(input bit dispatched);
    op_t next[$];
    op_t o;
    foreach (inflight[i]) begin
      o = inflight[i];
      if (flush_i && o.age <= COMMIT_AGE) o.poison = 1'b1;
      o.age++;
      if (o.age <= (o.imul ? IMUL_DEPTH : FMA_DEPTH)) next.push_back(o);
    end
    if (dispatched) begin
      o.age    = 1;
      o.imul   = issue_imul_i;
      o.rd     = issue_rd_i;
      o.poison = 1'b0;
      next.push_back(o);
    end
    inflight = next;
  endtask

  task automatic applyStimulus(input int issue_pct, input int flush_pct);
    bit p;
    bit [4:0] r;
    issue_v_i    = ($urandom_range(99) < issue_pct);
    issue_imul_i = $urandom_range(1) == 1;
    issue_rd_i   = 5'($urandom_range(7));
    issue_rs1_i  = 5'($urandom_range(7));
    issue_rs2_i  = 5'($urandom_range(7));
    issue_rs3_i  = 5'($urandom_range(7));
    issue_rs_v_i = 3'($urandom_range(7));
    flush_i      = ($urandom_range(99) < flush_pct);
    imul_v_i     = modelLast(1'b1, p, r);
    fma_v_i      = modelLast(1'b0, p, r);
  endtask

  task automatic runCycle();
    bit il, fl, ip, fp, rdy;
    bit [4:0] ir, fr;
    @(negedge clk_i);
    il  = modelLast(1'b1, ip, ir);
    fl  = modelLast(1'b0, fp, fr);
    rdy = modelReady();
    checkOutput("ready", 32'(issue_ready_o), 32'(rdy));
    checkOutput("dispatch", 32'(dispatch_v_o), 32'(issue_v_i & rdy));
    checkOutput("imul_wb_v", 32'(imul_wb_v_o), 32'(il & ~ip & imul_v_i));
    if (il) checkOutput("imul_wb_rd", 32'(imul_wb_rd_o), 32'(ir));
    checkOutput("fma_wb_v", 32'(fma_wb_v_o), 32'(fl & ~fp & fma_v_i));
    if (fl) checkOutput("fma_wb_rd", 32'(fma_wb_rd_o), 32'(fr));
    checkOutput("idle", 32'(idle_o), 32'(inflight.size() == 0));
    checkOutput("mismatch", 32'(mismatch_o), 32'(model_mismatch));
    if ((il != imul_v_i) || (fl != fma_v_i)) model_mismatch = 1'b1;
    modelStep(issue_v_i & rdy);
  endtask

  task automatic quietInputs();
    issue_v_i    = 1'b0;
    issue_imul_i = 1'b0;
    issue_rd_i   = 5'd0;
    issue_rs1_i  = 5'd0;
    issue_rs2_i  = 5'd0;
    issue_rs3_i  = 5'd0;
    issue_rs_v_i = 3'b000;
    flush_i      = 1'b0;
    imul_v_i     = 1'b0;
    fma_v_i      = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    model_mismatch = 1'b0;
    reset_i        = 1'b1;
    quietInputs();

    #12;
    checkOutput("reset_idle", 32'(idle_o), 32'd1);
    checkOutput("reset_mismatch", 32'(mismatch_o), 32'd0);
    checkOutput("reset_imul_wb_v", 32'(imul_wb_v_o), 32'd0);
    checkOutput("reset_fma_wb_v", 32'(fma_wb_v_o), 32'd0);
    checkOutput("reset_wb_rd", 32'({imul_wb_rd_o, fma_wb_rd_o}), 32'd0);
    checkOutput("reset_ready", 32'(issue_ready_o), 32'd1);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk_i); #1;
      applyStimulus((c < 750) ? 60 : 90, (c < 750) ? 8 : 3);
      runCycle();
    end

    // Drain the pipe so the stray-strobe case starts from an empty scoreboard.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      applyStimulus(0, 0);
      runCycle();
    end

    @(posedge clk_i); #1;
    quietInputs();
    imul_v_i = 1'b1;
    runCycle();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      quietInputs();
      runCycle();
    end

    // Asynchronous reset mid-cycle must clear the sticky error with no clock edge.
    @(posedge clk_i); #2;
    reset_i = 1'b1;
    #1;
    checkOutput("async_reset_mismatch", 32'(mismatch_o), 32'd0);
    checkOutput("async_reset_idle", 32'(idle_o), 32'd1);
    inflight.delete();
    model_mismatch = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int c = 0; c < 300; c++) begin
      @(posedge clk_i); #1;
      applyStimulus(80, 5);
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
